// File: rtl/smart_home_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smart_home_pkg
// Description : Shared field widths, record layout, FSM encoding and record
//               packing helpers for the smart-home snapshot datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package smart_home_pkg;

    localparam int FIELD_W   = 7;
    localparam int SEQ_W     = 6;
    localparam int REC_W     = 35;

    localparam int PAR_BIT   = 34;
    localparam int SEQ_LSB   = 28;
    localparam int TEMP_LSB  = 21;
    localparam int HUM_LSB   = 14;
    localparam int LIGHT_LSB = 7;
    localparam int FLAGS_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] temp;
        logic [FIELD_W-1:0] hum;
        logic [FIELD_W-1:0] light;
        logic [FIELD_W-1:0] flags;
    } fields_t;

    // Even parity over the whole record: the parity bit is the XOR of the body.
    function automatic logic calc_parity(input logic [REC_W-2:0] body);
        return ^body;
    endfunction

    function automatic logic [REC_W-1:0] pack_record(
        input logic [SEQ_W-1:0] seq,
        input fields_t          f
    );
        logic [REC_W-1:0] rec;
        rec                        = '0;
        rec[SEQ_LSB   +: SEQ_W]    = seq;
        rec[TEMP_LSB  +: FIELD_W]  = f.temp;
        rec[HUM_LSB   +: FIELD_W]  = f.hum;
        rec[LIGHT_LSB +: FIELD_W]  = f.light;
        rec[FLAGS_LSB +: FIELD_W]  = f.flags;
        rec[PAR_BIT]               = calc_parity(rec[PAR_BIT-1:0]);
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snapshot_packer.sv
`default_nettype none
// ============================================================================
// Module      : snapshot_packer
// Description : Captures sensor snapshots on sample ticks and writes a
//               parity-protected record when data changes or on heartbeat.
// Revision    : 1.0 - initial release
// ============================================================================
module snapshot_packer
    import smart_home_pkg::*;
#(
    parameter int unsigned HEARTBEAT_TICKS = 8
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               sample_tick,
    input  logic [FIELD_W-1:0] temp,
    input  logic [FIELD_W-1:0] hum,
    input  logic [FIELD_W-1:0] light,
    input  logic [FIELD_W-1:0] flags,
    output logic [REC_W-1:0]   mem_din,
    output logic               mem_wren,
    output logic               busy,
    output logic               drop_pulse
);

    localparam logic [7:0] HB_LAST = 8'(HEARTBEAT_TICKS - 1);

    state_t             state;
    fields_t            cap;
    fields_t            last;
    logic [SEQ_W-1:0]   seq;
    logic [7:0]         hb_cnt;
    logic               first_flag;
    logic               do_write;

    assign do_write = (cap != last) || first_flag || (hb_cnt == HB_LAST);

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= ST_IDLE;
            cap        <= '0;
            last       <= '0;
            seq        <= '0;
            hb_cnt     <= '0;
            first_flag <= 1'b1;
            mem_din    <= '0;
            mem_wren   <= 1'b0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            // Ticks arriving while a snapshot is in flight are discarded, not queued.
            drop_pulse <= sample_tick && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    mem_wren <= 1'b0;
                    if (sample_tick) begin
                        cap   <= '{temp: temp, hum: hum, light: light, flags: flags};
                        state <= ST_COMPARE;
                        busy  <= 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (do_write) begin
                        mem_din  <= pack_record(seq, cap);
                        mem_wren <= 1'b1;
                        state    <= ST_WRITE;
                    end else begin
                        hb_cnt   <= hb_cnt + 8'd1;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // Bookkeeping commits only once the write cycle completes.
                    mem_wren   <= 1'b0;
                    last       <= cap;
                    hb_cnt     <= '0;
                    first_flag <= 1'b0;
                    seq        <= seq + 6'd1;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    mem_wren <= 1'b0;
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
